// File: rtl/demux_scheduler_pkg.sv
// Shared definitions for the demux scheduler slice.
//   NUM_CH        : number of demux output channels
//   CH_A..CH_D    : select encodings driven on sel (sel[1]=s1, sel[0]=s2)
//   chan_t        : channel index / select pair type
//   buf_state_t   : one-entry buffer occupancy
package demux_scheduler_pkg;

   localparam int unsigned NUM_CH = 4;

   typedef logic [1:0] chan_t;

   localparam chan_t CH_A = 2'b00;
   localparam chan_t CH_B = 2'b01;
   localparam chan_t CH_C = 2'b10;
   localparam chan_t CH_D = 2'b11;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } buf_state_t;

endpackage

// File: rtl/demux_scheduler_rr_next_chan.sv
// Round-robin channel search.
//   sel         : current channel pointer
//   chan_mask   : per-channel enable, bit k set means channel k is eligible
//   next_chan   : first enabled channel strictly after sel (wrapping); sel
//                 itself when no other channel is enabled
//   any_enabled : at least one channel is enabled
module rr_next_chan
   import demux_scheduler_pkg::*;
(
   input  logic [1:0]        sel,
   input  logic [NUM_CH-1:0] chan_mask,
   output logic [1:0]        next_chan,
   output logic              any_enabled
);

   chan_t cand;
   logic  found;

   always_comb begin
      next_chan   = sel;
      any_enabled = |chan_mask;
      cand        = sel;
      found       = 1'b0;
      // Candidates sel+1, sel+2, sel+3 in circular order; 2-bit add wraps.
      for (int unsigned i = 1; i < NUM_CH; i++) begin
         cand = sel + chan_t'(i);
         if (!found && chan_mask[cand]) begin
            next_chan = cand;
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/demux_scheduler.sv
// Sequencing controller for the 1-to-4 enable/select demux datapath.
// Words arrive over a valid/ready handshake into a one-entry buffer and are
// distributed round-robin over the enabled channels, BURST words per channel.
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   in_valid   : upstream word valid
//   in_data    : upstream word
//   in_ready   : a word can be accepted this cycle
//   chan_mask  : per-channel enable
//   out_ready  : per-channel downstream ready (only the selected bit matters)
//   out_valid  : one-hot valid for the selected channel while the buffer is full
//   out_data   : buffered word, shared by all channels
//   sel        : demux select pair, 00=a 01=b 10=c 11=d
//   en         : demux enable, equals buffer-full
//   busy       : buffer full, or pointer seeking an enabled channel
module demux_scheduler
   import demux_scheduler_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned BURST = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [WIDTH-1:0]  in_data,
   output logic              in_ready,
   input  logic [NUM_CH-1:0] chan_mask,
   input  logic [NUM_CH-1:0] out_ready,
   output logic [NUM_CH-1:0] out_valid,
   output logic [WIDTH-1:0]  out_data,
   output logic [1:0]        sel,
   output logic              en,
   output logic              busy
);

   localparam int unsigned CW = $clog2(BURST) + 1;
   // Counting 0..BURST-1 and wrapping on the last value is the same as
   // incrementing to BURST and clearing.
   localparam logic [CW-1:0] BURST_LAST = CW'(BURST - 1);

   buf_state_t     state, state_d;
   chan_t          sel_q, sel_d;
   logic [CW-1:0]  burst_cnt, burst_cnt_d;
   logic [WIDTH-1:0] data_q;

   chan_t next_chan;
   logic  any_enabled;
   logic  is_full;
   logic  xfer;
   logic  accept;
   logic  seeking;

   rr_next_chan u_rr_next_chan (
      .sel         (sel_q),
      .chan_mask   (chan_mask),
      .next_chan   (next_chan),
      .any_enabled (any_enabled)
   );

   assign is_full  = (state == FULL);
   assign xfer     = is_full && out_ready[sel_q];
   assign in_ready = chan_mask[sel_q] && (!is_full || out_ready[sel_q]);
   assign accept   = in_valid && in_ready;
   // With nothing enabled the pointer has nowhere to go, so it is idle.
   assign seeking  = !is_full && !chan_mask[sel_q] && any_enabled;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= EMPTY;
         sel_q     <= CH_A;
         burst_cnt <= '0;
         data_q    <= '0;
      end else begin
         state     <= state_d;
         sel_q     <= sel_d;
         burst_cnt <= burst_cnt_d;
         if (accept) begin
            data_q <= in_data;
         end
      end
   end

   always_comb begin
      state_d     = state;
      sel_d       = sel_q;
      burst_cnt_d = burst_cnt;
      if (xfer) begin
         state_d = EMPTY;
         if (burst_cnt == BURST_LAST) begin
            burst_cnt_d = '0;
            sel_d       = next_chan;
         end else begin
            burst_cnt_d = burst_cnt + CW'(1);
         end
      end else if (seeking) begin
         sel_d       = next_chan;
         burst_cnt_d = '0;
      end
      // A word accepted alongside a transfer lands on the post-advance sel.
      if (accept) begin
         state_d = FULL;
      end
   end

   assign en        = is_full;
   assign sel       = sel_q;
   assign out_data  = data_q;
   assign out_valid = is_full ? (NUM_CH'(1) << sel_q) : '0;
   assign busy      = is_full || seeking;

endmodule
